// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write link: frame geometry,
// peripheral register map and the initiator state encoding.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic SPI_WRITE = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_controller_if.sv
// Command handshake between a register-write requester and the SPI initiator.
interface spi_controller_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one {rw, addr, data} command into a 16-bit
// MSB-first frame. Every pin and handshake output is driven straight from a flop.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_controller_if.slave cmd,
  output logic            sclk,
  output logic            ncs,
  output logic            copi,
  output logic            busy,
  output logic            done
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_controller: CLK_DIV must lie in 2..255");
  end

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_MSB = 4'(FRAME_BITS - 1);

  spi_state_e            state_q, state_d;
  logic [7:0]            ph_q, ph_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic                  sclk_q, sclk_d;
  logic                  ncs_q, ncs_d;
  logic                  copi_q, copi_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ph_end;

  assign ph_end = (ph_q == PH_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_end ? 8'd0 : ph_q + 8'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ph_d = '0;
        if (cmd.cmd_valid && rdy_q) begin
          sh_d    = {cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data};
          ncs_d   = 1'b0;
          copi_d  = cmd.cmd_rw;
          sclk_d  = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ph_end) begin
          bit_d   = BIT_MSB;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ph_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              // Rotate rather than shift so the latched frame stays intact.
              bit_d  = bit_q - 4'd1;
              sh_d   = {sh_q[FRAME_BITS-2:0], sh_q[FRAME_BITS-1]};
              copi_d = sh_q[FRAME_BITS-2];
            end
          end
        end
      end
      HOLD: begin
        if (ph_end) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (ph_end) begin
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd.cmd_ready = rdy_q;
  assign sclk          = sclk_q;
  assign ncs           = ncs_q;
  assign copi          = copi_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a CLK_DIV=4 and a CLK_DIV=2 instance,
// each watched by a frame decoder that also models the peripheral registers.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_controller_if cif0 ();
  spi_controller_if cif1 ();

  logic [1:0] sclk, ncs, copi, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] expq0[$];
  logic [15:0] expq1[$];

  spi_controller #(.CLK_DIV(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(cif0),
    .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0]), .busy(busy[0]), .done(done[0])
  );

  spi_controller #(.CLK_DIV(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(cif1),
    .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame decoder per instance: samples copi on sclk rises while ncs is low.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int H = (g == 0) ? 4 : 2;
    logic [15:0] sh = '0;
    int nb = 0, lowc = 0, highc = 0, gap_cnt = 0, done_cnt = 0, aborted = 0;
    logic pn = 1'b1, ps = 1'b0, pc = 1'b0;
    logic [7:0] regs [0:127] = '{default: 8'h00};

    always @(negedge clk) begin : mon
      logic [15:0] e;
      logic        have;
      if (ncs[g] === 1'b0) begin
        if (pn !== 1'b0) begin
          gap_cnt = highc;
          nb      = 0;
          lowc    = 0;
          sh      = '0;
        end
        lowc++;
        if (sclk[g] === 1'b1 && ps === 1'b0) begin
          sh = {sh[14:0], copi[g]};
          nb++;
        end else if (sclk[g] === 1'b1 && ps === 1'b1) begin
          chk($sformatf("copi_stable%0d", g), 32'(copi[g]), 32'(pc));
        end
      end else if (ncs[g] === 1'b1) begin
        if (pn === 1'b0) begin
          highc = 0;
          if (nb == 16) begin
            have = 1'b0;
            e    = '0;
            if (g == 0 && expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
            if (g == 1 && expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
            if (!have) begin
              checks++;
              failures++;
              $display("FAIL sb_empty%0d unexpected frame=0x%0h", g, sh);
            end else begin
              chk($sformatf("frame%0d", g), 32'(sh), 32'(e));
              chk($sformatf("ncs_low_cycles%0d", g), lowc, 34 * H);
              chk($sformatf("done_at_end%0d", g), 32'(done[g]), 32'd1);
              if (sh[15] == SPI_WRITE) regs[sh[14:8]] = sh[7:0];
            end
          end else begin
            aborted++;
          end
        end
        highc++;
      end
      if (done[g] === 1'b1) done_cnt++;
      pn = ncs[g];
      ps = sclk[g];
      pc = copi[g];
    end
  end

  function automatic logic rdy(input bit i);
    return i ? cif1.cmd_ready : cif0.cmd_ready;
  endfunction

  task automatic drv(input bit i, input logic v, input logic rw, input logic [6:0] a,
                     input logic [7:0] d);
    if (!i) begin
      cif0.cmd_valid = v; cif0.cmd_rw = rw; cif0.cmd_addr = a; cif0.cmd_data = d;
    end else begin
      cif1.cmd_valid = v; cif1.cmd_rw = rw; cif1.cmd_addr = a; cif1.cmd_data = d;
    end
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic send(input bit i, input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] exp_frame, input bit push, input bit hold);
    int n = 0;
    drv(i, 1'b1, rw, a, d);
    while (rdy(i) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout%0d actual=not_ready required=ready", i);
    end else if (push) begin
      if (!i) expq0.push_back(exp_frame);
      else    expq1.push_back(exp_frame);
    end
    @(negedge clk);
    if (!hold) drv(i, 1'b0, rw, a, d);
  endtask

  task automatic wait_idle(input bit i);
    int n = 0;
    @(negedge clk);
    while (rdy(i) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout%0d actual=busy required=idle", i);
    end
  endtask

  task automatic chk_idle(input string tag, input bit i);
    chk({tag, "_ncs"},   32'(ncs[i]),  32'd1);
    chk({tag, "_sclk"},  32'(sclk[i]), 32'd0);
    chk({tag, "_copi"},  32'(copi[i]), 32'd0);
    chk({tag, "_ready"}, 32'(rdy(i)),  32'd1);
    chk({tag, "_busy"},  32'(busy[i]), 32'd0);
    chk({tag, "_done"},  32'(done[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    drv(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk_idle("reset0", 1'b0);
    chk_idle("reset1", 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    send(1'b0, SPI_WRITE, ADDR_EN_OUT_7_0, 8'hF0, 16'h80F0, 1'b1, 1'b0);
    wait_idle(1'b0);
    chk("en_out_7_0", 32'(g_mon[0].regs[0]), 32'h0F0);

    send(1'b1, SPI_WRITE, ADDR_PWM_DUTY, 8'h80, 16'h8480, 1'b1, 1'b0);
    wait_idle(1'b1);
    chk("pwm_duty", 32'(g_mon[1].regs[4]), 32'h080);

    send(1'b0, SPI_WRITE, ADDR_EN_PWM_7_0, 8'hFF, 16'h82FF, 1'b1, 1'b1);
    send(1'b0, SPI_WRITE, ADDR_EN_PWM_15_8, 8'h0F, 16'h830F, 1'b1, 1'b0);
    wait_idle(1'b0);
    chk("b2b_ncs_gap", g_mon[0].gap_cnt, 5);
    chk("en_pwm_7_0", 32'(g_mon[0].regs[2]), 32'h0FF);
    chk("en_pwm_15_8", 32'(g_mon[0].regs[3]), 32'h00F);

    send(1'b0, SPI_WRITE, ADDR_EN_OUT_15_8, 8'h3C, 16'h813C, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    drv(1'b0, 1'b1, SPI_WRITE, ADDR_EN_OUT_15_8, 8'h55);
    chk("busy_mid_frame", 32'(busy[0]), 32'd1);
    @(negedge clk);
    drv(1'b0, 1'b0, SPI_WRITE, ADDR_EN_OUT_15_8, 8'h55);
    wait_idle(1'b0);
    repeat (10) @(negedge clk);
    chk("busy_no_extra", expq0.size(), 0);
    chk("busy_done_cnt", g_mon[0].done_cnt, 4);
    chk("en_out_15_8", 32'(g_mon[0].regs[1]), 32'h03C);

    send(1'b0, 1'b0, ADDR_EN_OUT_15_8, 8'h99, 16'h0199, 1'b1, 1'b0);
    wait_idle(1'b0);
    chk("read_regs_kept", 32'(g_mon[0].regs[1]), 32'h03C);
    chk("read_done_cnt", g_mon[0].done_cnt, 5);

    send(1'b0, SPI_WRITE, ADDR_EN_OUT_7_0, 8'h11, 16'h8011, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("rst_mid", 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_aborted", g_mon[0].aborted, 1);
    chk("rst_no_done", g_mon[0].done_cnt, 5);
    chk("rst_regs_kept", 32'(g_mon[0].regs[0]), 32'h0F0);

    send(1'b0, SPI_WRITE, ADDR_EN_OUT_15_8, 8'hA5, 16'h81A5, 1'b1, 1'b0);
    wait_idle(1'b0);
    chk("recover_reg", 32'(g_mon[0].regs[1]), 32'h0A5);
    chk("final_done0", g_mon[0].done_cnt, 6);
    chk("final_done1", g_mon[1].done_cnt, 1);
    chk("final_aborted1", g_mon[1].aborted, 0);
    chk("final_q0", expq0.size(), 0);
    chk("final_q1", expq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI initiator that turns a parallel register-write command into one 16-bit SPI frame on sclk/ncs/copi. It is the counterpart to spi_peripheral, which receives and decodes these frames. It is used by the on-chip bring-up sequencer and by the testbench to program the output-enable, PWM-enable and duty-cycle registers. Frames are SPI mode 0, MSB first, in this format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255; gives an 8-bit phase counter.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle; a command is accepted on a clk edge where cmd_valid & cmd_ready
cmd_rw  in  1  frame bit15 (1 = write)
cmd_addr  in  7  frame bits14:8
cmd_data  in  8  frame bits7:0
sclk  out  1  SPI clock, idle low
ncs  out  1  chip select, active low, idle high
copi  out  1  serial data, MSB first
busy  out  1  high from acceptance until cmd_ready returns high
done  out  1  one-cycle pulse when a frame completes

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low (rst_n). All outputs are driven directly from flops, so they are glitch-free.
- Reset values: sclk = 0, ncs = 1, copi = 0, cmd_ready = 1, busy = 0, done = 0; state IDLE; shift register and counters cleared.
- Let H = CLK_DIV. The phase counter counts H cycles per phase.
- State IDLE: cmd_ready = 1.
  - On acceptance edge E0, latch frame = {cmd_rw, cmd_addr, cmd_data}.
  - Also at E0: ncs <= 0, copi <= frame[15], sclk <= 0, cmd_ready <= 0, busy <= 1; go to SETUP.
- State SETUP: H cycles with ncs low, sclk low and bit15 on copi; then go to SHIFT.
- State SHIFT: 16 bits, each lasting 2H cycles.
  - Low phase: H cycles, sclk = 0.
  - High phase: H cycles, sclk = 1.
  - copi changes only at the start of a low phase, never while sclk is high.
  - The peripheral samples on the rising edge.
  - Bit counter counts 15 down to 0. After the high phase of bit 0, go to HOLD.
- State HOLD: H cycles with sclk = 0 and ncs still low; copi holds bit 0.
- Frame end: at the end of HOLD, ncs <= 1, copi <= 0, done <= 1 for exactly one cycle; go to GAP.
- State GAP: H cycles with ncs high; then cmd_ready <= 1, busy <= 0; go to IDLE.
- Timing totals:
  - ncs is low for exactly 34H cycles.
  - Acceptance to done: 34H cycles.
  - Minimum accept-to-accept interval: 35H + 1 cycles.
  - Exactly 16 sclk rising edges per frame.
- Command inputs are sampled only at acceptance. Changes to cmd_valid or cmd_* while busy are ignored, and the latched frame is never modified mid-frame.
- No queuing: a command offered while cmd_ready = 0 is simply not accepted. It is accepted on the first cycle cmd_ready = 1 if still valid.
- Back-to-back: with cmd_valid held high, the next acceptance happens on the first IDLE cycle. ncs rises again only after GAP, so ncs is always high for at least H cycles.
- cmd_rw = 0 frames are transmitted unchanged. There is no CIPO path; read data is out of scope.
- Reset mid-frame: on the first clk edge with rst_n low, all outputs take their reset values and the state goes to IDLE. The frame is discarded and no done pulse is produced. A partially sent frame leaves the peripheral unchanged because ncs rises before bit 16.
- CLK_DIV = 2 must work against spi_peripheral's 2-flop synchronisers. Values below 2 are illegal; flag them with an elaboration-time check.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS = 16, ADDR_W = 7, DATA_W = 8, SPI_WRITE = 1'b1.
  - Register addresses: ADDR_EN_OUT_7_0 = 0x00, ADDR_EN_OUT_15_8 = 0x01, ADDR_EN_PWM_7_0 = 0x02, ADDR_EN_PWM_15_8 = 0x03, ADDR_PWM_DUTY = 0x04.
  - State enum: IDLE, SETUP, SHIFT, HOLD, GAP.
- No sub-module. The phase counter, bit counter and 16-bit shift register live in spi_controller.

Test Plan:
- Reset: assert rst_n low for 3 cycles in the middle of SHIFT -> next edge ncs = 1, sclk = 0, copi = 0, cmd_ready = 1; no done; the looped-back spi_peripheral registers are unchanged.
- Write, CLK_DIV = 4, addr 0x00, data 0xF0 -> copi bit sequence 1_0000000_11110000; 16 sclk rises; ncs low for 136 cycles; one done pulse; spi_peripheral en_reg_out_7_0 = 0xF0.
- Write addr 0x04, data 0x80 with CLK_DIV = 2 -> pwm_duty_cycle = 0x80; ncs low for 68 cycles.
- Back-to-back: cmd_valid held across writes 0x02/0xFF then 0x03/0x0F -> second acceptance on the first cycle cmd_ready = 1; ncs high gap of at least 4 cycles; en_reg_pwm_7_0 = 0xFF and en_reg_pwm_15_8 = 0x0F.
- Busy interference: during a frame, change cmd_data to 0x55 and pulse cmd_valid -> the transmitted frame is unchanged and the pulse is not accepted.
- Read frame: rw = 0, addr 0x01 -> bit15 on copi is 0, 16 rises, done pulses; peripheral registers unchanged.
